// File: rtl/id_ex_hazard_pipe_pkg.sv
// rtl/id_ex_hazard_pipe_pkg.sv - shared control-word layout and EX update actions for the ID/EX stage
package id_ex_hazard_pipe_pkg;

    localparam int DEF_CONTROL_SIZE = 18;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_REG_ADDR     = 5;
    localparam int DEF_CNT_WIDTH    = 16;
    localparam int SHAMT_W          = 5;

    localparam int REG_WRITE = 0;
    localparam int MEM_READ  = 3;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_LOAD   = 2'd2
    } ex_action_e;

    function automatic ex_action_e pick_action(input logic halt, input logic flush,
                                               input logic hz);
        if (halt)
            return ACT_HOLD;
        else if (flush || hz)
            return ACT_BUBBLE;
        else
            return ACT_LOAD;
    endfunction

endpackage

// File: rtl/id_ex_hazard_pipe_load_use_detect.sv
// rtl/id_ex_hazard_pipe_load_use_detect.sv - combinational load-use compare between EX load and ID sources
module load_use_detect #(
    parameter int REG_ADDR = 5
) (
    input  logic                ex_valid,
    input  logic                ex_mem_read,
    input  logic [REG_ADDR-1:0] ex_rt_addr,
    input  logic [REG_ADDR-1:0] id_rs_addr,
    input  logic [REG_ADDR-1:0] id_rt_addr,
    output logic                hz
);

    // A load into $0 never produces a value, so it can never create a hazard.
    always_comb begin
        hz = ex_valid && ex_mem_read && (ex_rt_addr != '0) &&
             ((ex_rt_addr == id_rs_addr) || (ex_rt_addr == id_rt_addr));
    end

endmodule

// File: rtl/id_ex_hazard_pipe.sv
// rtl/id_ex_hazard_pipe.sv - ID/EX pipeline register with load-use stall, flush, halt and bubble counter
module id_ex_hazard_pipe
    import id_ex_hazard_pipe_pkg::*;
#(
    parameter int CONTROL_SIZE = DEF_CONTROL_SIZE,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int REG_ADDR     = DEF_REG_ADDR,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_halt,
    input  logic                    i_flush,
    input  logic [CONTROL_SIZE-1:0] i_control,
    input  logic [REG_ADDR-1:0]     i_rs_addr,
    input  logic [REG_ADDR-1:0]     i_rt_addr,
    input  logic [REG_ADDR-1:0]     i_rd_addr,
    input  logic [SHAMT_W-1:0]      i_shamt,
    input  logic [DATA_WIDTH-1:0]   i_rs_data,
    input  logic [DATA_WIDTH-1:0]   i_rt_data,
    input  logic [DATA_WIDTH-1:0]   i_imm,
    input  logic [DATA_WIDTH-1:0]   i_pc4,
    output logic                    o_ctrl_enable,
    output logic                    o_pc_write,
    output logic                    o_ifid_write,
    output logic [CONTROL_SIZE-1:0] o_ex_control,
    output logic                    o_ex_valid,
    output logic [REG_ADDR-1:0]     o_ex_rs_addr,
    output logic [REG_ADDR-1:0]     o_ex_rt_addr,
    output logic [REG_ADDR-1:0]     o_ex_rd_addr,
    output logic [SHAMT_W-1:0]      o_ex_shamt,
    output logic [DATA_WIDTH-1:0]   o_ex_rs_data,
    output logic [DATA_WIDTH-1:0]   o_ex_rt_data,
    output logic [DATA_WIDTH-1:0]   o_ex_imm,
    output logic [DATA_WIDTH-1:0]   o_ex_pc4,
    output logic [CNT_WIDTH-1:0]    o_bubble_count
);

    logic [CONTROL_SIZE-1:0] control_q, control_d;
    logic                    valid_q, valid_d;
    logic [REG_ADDR-1:0]     rs_addr_q, rs_addr_d;
    logic [REG_ADDR-1:0]     rt_addr_q, rt_addr_d;
    logic [REG_ADDR-1:0]     rd_addr_q, rd_addr_d;
    logic [SHAMT_W-1:0]      shamt_q, shamt_d;
    logic [DATA_WIDTH-1:0]   rs_data_q, rs_data_d;
    logic [DATA_WIDTH-1:0]   rt_data_q, rt_data_d;
    logic [DATA_WIDTH-1:0]   imm_q, imm_d;
    logic [DATA_WIDTH-1:0]   pc4_q, pc4_d;
    logic [CNT_WIDTH-1:0]    bubble_count_q, bubble_count_d;

    logic       hz;
    ex_action_e action;

    load_use_detect #(
        .REG_ADDR (REG_ADDR)
    ) u_load_use_detect (
        .ex_valid    (valid_q),
        .ex_mem_read (control_q[MEM_READ]),
        .ex_rt_addr  (rt_addr_q),
        .id_rs_addr  (i_rs_addr),
        .id_rt_addr  (i_rt_addr),
        .hz          (hz)
    );

    // Flush redirects fetch, so only the hazard and halt gate PC / IF-ID writes.
    always_comb begin
        o_ctrl_enable = ~hz;
        o_pc_write    = ~i_halt & ~hz;
        o_ifid_write  = ~i_halt & ~hz;
        action        = pick_action(i_halt, i_flush, hz);
    end

    always_comb begin
        control_d      = control_q;
        valid_d        = valid_q;
        rs_addr_d      = rs_addr_q;
        rt_addr_d      = rt_addr_q;
        rd_addr_d      = rd_addr_q;
        shamt_d        = shamt_q;
        rs_data_d      = rs_data_q;
        rt_data_d      = rt_data_q;
        imm_d          = imm_q;
        pc4_d          = pc4_q;
        bubble_count_d = bubble_count_q;
        case (action)
            ACT_BUBBLE: begin
                control_d = '0;
                valid_d   = 1'b0;
                rs_addr_d = '0;
                rt_addr_d = '0;
                rd_addr_d = '0;
                shamt_d   = '0;
                rs_data_d = '0;
                rt_data_d = '0;
                imm_d     = '0;
                pc4_d     = '0;
                // Flush and hazard in the same cycle still insert a single bubble.
                if (!(&bubble_count_q))
                    bubble_count_d = bubble_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            ACT_LOAD: begin
                control_d = i_control;
                valid_d   = |i_control;
                rs_addr_d = i_rs_addr;
                rt_addr_d = i_rt_addr;
                rd_addr_d = i_rd_addr;
                shamt_d   = i_shamt;
                rs_data_d = i_rs_data;
                rt_data_d = i_rt_data;
                imm_d     = i_imm;
                pc4_d     = i_pc4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            control_q      <= '0;
            valid_q        <= 1'b0;
            rs_addr_q      <= '0;
            rt_addr_q      <= '0;
            rd_addr_q      <= '0;
            shamt_q        <= '0;
            rs_data_q      <= '0;
            rt_data_q      <= '0;
            imm_q          <= '0;
            pc4_q          <= '0;
            bubble_count_q <= '0;
        end else begin
            control_q      <= control_d;
            valid_q        <= valid_d;
            rs_addr_q      <= rs_addr_d;
            rt_addr_q      <= rt_addr_d;
            rd_addr_q      <= rd_addr_d;
            shamt_q        <= shamt_d;
            rs_data_q      <= rs_data_d;
            rt_data_q      <= rt_data_d;
            imm_q          <= imm_d;
            pc4_q          <= pc4_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign o_ex_control   = control_q;
    assign o_ex_valid     = valid_q;
    assign o_ex_rs_addr   = rs_addr_q;
    assign o_ex_rt_addr   = rt_addr_q;
    assign o_ex_rd_addr   = rd_addr_q;
    assign o_ex_shamt     = shamt_q;
    assign o_ex_rs_data   = rs_data_q;
    assign o_ex_rt_data   = rt_data_q;
    assign o_ex_imm       = imm_q;
    assign o_ex_pc4       = pc4_q;
    assign o_bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_hazard_pipe.sv
// tb/tb_id_ex_hazard_pipe.sv - randomized and directed self-checking bench for id_ex_hazard_pipe
module tb_id_ex_hazard_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, halt, flush;
    logic [17:0] ctrl;
    logic [4:0]  rs_a, rt_a, rd_a, shamt;
    logic [31:0] rs_d, rt_d, imm, pc4;

    logic        ctrl_en, pc_wr, ifid_wr, ex_valid;
    logic [17:0] ex_ctrl;
    logic [4:0]  ex_rs_a, ex_rt_a, ex_rd_a, ex_shamt;
    logic [31:0] ex_rs_d, ex_rt_d, ex_imm, ex_pc4;
    logic [15:0] bcount;

    int checks = 0;
    int failures = 0;

    // Reference model of the EX slot and bubble tally
    logic [17:0] m_ctrl;
    logic        m_valid;
    logic [4:0]  m_rs_a, m_rt_a, m_rd_a, m_shamt;
    logic [31:0] m_rs_d, m_rt_d, m_imm, m_pc4;
    int          m_cnt;

    id_ex_hazard_pipe dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_halt         (halt),
        .i_flush        (flush),
        .i_control      (ctrl),
        .i_rs_addr      (rs_a),
        .i_rt_addr      (rt_a),
        .i_rd_addr      (rd_a),
        .i_shamt        (shamt),
        .i_rs_data      (rs_d),
        .i_rt_data      (rt_d),
        .i_imm          (imm),
        .i_pc4          (pc4),
        .o_ctrl_enable  (ctrl_en),
        .o_pc_write     (pc_wr),
        .o_ifid_write   (ifid_wr),
        .o_ex_control   (ex_ctrl),
        .o_ex_valid     (ex_valid),
        .o_ex_rs_addr   (ex_rs_a),
        .o_ex_rt_addr   (ex_rt_a),
        .o_ex_rd_addr   (ex_rd_a),
        .o_ex_shamt     (ex_shamt),
        .o_ex_rs_data   (ex_rs_d),
        .o_ex_rt_data   (ex_rt_d),
        .o_ex_imm       (ex_imm),
        .o_ex_pc4       (ex_pc4),
        .o_bubble_count (bcount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_valid = 1'b0; m_rs_a = '0; m_rt_a = '0; m_rd_a = '0; m_shamt = '0;
        m_rs_d = '0; m_rt_d = '0; m_imm = '0; m_pc4 = '0; m_cnt = 0;
    endtask

    function automatic bit model_hz();
        return m_valid && m_ctrl[3] && (m_rt_a != 5'd0) && ((m_rt_a == rs_a) || (m_rt_a == rt_a));
    endfunction

    task automatic model_step();
        bit hz;
        hz = model_hz();
        if (halt) begin
        end else if (flush || hz) begin
            m_ctrl = '0; m_valid = 1'b0; m_rs_a = '0; m_rt_a = '0; m_rd_a = '0; m_shamt = '0;
            m_rs_d = '0; m_rt_d = '0; m_imm = '0; m_pc4 = '0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
            m_ctrl = ctrl; m_valid = (ctrl != 18'd0); m_rs_a = rs_a; m_rt_a = rt_a; m_rd_a = rd_a;
            m_shamt = shamt; m_rs_d = rs_d; m_rt_d = rt_d; m_imm = imm; m_pc4 = pc4;
        end
    endtask

    task automatic set_instr(input logic [17:0] c, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd);
        ctrl = c; rs_a = rs; rt_a = rt; rd_a = rd; shamt = 5'($urandom);
        rs_d = $urandom; rt_d = $urandom; imm = $urandom; pc4 = $urandom;
    endtask

    task automatic rand_inputs();
        ctrl = 18'($urandom);
        if ($urandom_range(0, 3) == 0) ctrl = '0;
        if ($urandom_range(0, 1) == 0) ctrl[3] = 1'b1;
        set_instr(ctrl, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
    endtask

    task automatic test_reset();
        halt = 1'b0; flush = 1'b0; rst_n = 1'b0;
        rand_inputs();
        tick(); tick();
        checks++;
        if ({ex_ctrl, ex_valid, ex_rs_a, ex_rt_a, ex_rd_a, ex_shamt, ex_rs_d, ex_rt_d, ex_imm, ex_pc4} !== '0) begin
            failures++; $display("FAIL reset_ex: got ctrl=%h valid=%b rs_d=%h want all zero", ex_ctrl, ex_valid, ex_rs_d);
        end
        checks++;
        if ({bcount, ctrl_en, pc_wr, ifid_wr} !== {16'd0, 3'b111}) begin
            failures++; $display("FAIL reset_out: got count=%0d en/pc/ifid=%b%b%b want 0 111", bcount, ctrl_en, pc_wr, ifid_wr);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_normal();
        set_instr(18'h00385, 5'd1, 5'd2, 5'd3);
        rs_d = 32'd5; rt_d = 32'd7;
        tick();
        model_step();
        checks++;
        if ({ex_ctrl, ex_valid, ex_rs_a, ex_rt_a, ex_rd_a, ex_rs_d, ex_rt_d} !==
            {18'h00385, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7}) begin
            failures++; $display("FAIL normal_addu: got ctrl=%h v=%b rs=%0d rt=%0d rd=%0d a=%0d b=%0d want 00385 1 1 2 3 5 7",
                                 ex_ctrl, ex_valid, ex_rs_a, ex_rt_a, ex_rd_a, ex_rs_d, ex_rt_d);
        end
        set_instr(18'h0, 5'd4, 5'd5, 5'd6);
        tick();
        model_step();
        checks++;
        if (ex_valid !== 1'b0 || ex_rs_a !== 5'd4) begin
            failures++; $display("FAIL normal_nop: got valid=%b rs=%0d want 0 4", ex_valid, ex_rs_a);
        end
    endtask

    task automatic test_load_use();
        int c0;
        c0 = m_cnt;
        set_instr(18'h00409, 5'd9, 5'd8, 5'd0);
        tick(); model_step();
        set_instr(18'h00385, 5'd8, 5'd1, 5'd10);
        #1;
        checks++;
        if ({pc_wr, ifid_wr, ctrl_en} !== 3'b000) begin
            failures++; $display("FAIL lu_stall: got pc/ifid/en=%b%b%b want 000", pc_wr, ifid_wr, ctrl_en);
        end
        tick(); model_step();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 18'h0 || bcount !== 16'(c0 + 1) || pc_wr !== 1'b1 || ctrl_en !== 1'b1) begin
            failures++; $display("FAIL lu_bubble: got valid=%b ctrl=%h count=%0d pc=%b en=%b want 0 0 %0d 1 1",
                                 ex_valid, ex_ctrl, bcount, pc_wr, ctrl_en, c0 + 1);
        end
        tick(); model_step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rs_a !== 5'd8 || ex_rd_a !== 5'd10 || bcount !== 16'(c0 + 1)) begin
            failures++; $display("FAIL lu_resume: got valid=%b rs=%0d rd=%0d count=%0d want 1 8 10 %0d",
                                 ex_valid, ex_rs_a, ex_rd_a, bcount, c0 + 1);
        end
        // Reset asserted between edges while a stall is pending
        set_instr(18'h00409, 5'd0, 5'd8, 5'd0);
        tick(); model_step();
        set_instr(18'h00385, 5'd1, 5'd8, 5'd2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pc_wr !== 1'b1 || ex_valid !== 1'b0 || bcount !== 16'd0) begin
            failures++; $display("FAIL reset_mid_stall: got pc=%b valid=%b count=%0d want 1 0 0", pc_wr, ex_valid, bcount);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic test_lw_zero();
        set_instr(18'h00409, 5'd3, 5'd0, 5'd0);
        tick(); model_step();
        set_instr(18'h00385, 5'd0, 5'd0, 5'd4);
        #1;
        checks++;
        if (pc_wr !== 1'b1 || ctrl_en !== 1'b1) begin
            failures++; $display("FAIL lw_zero_enable: got pc=%b en=%b want 1 1", pc_wr, ctrl_en);
        end
        tick(); model_step();
        checks++;
        if (bcount !== 16'd0 || ex_valid !== 1'b1 || ex_rd_a !== 5'd4) begin
            failures++; $display("FAIL lw_zero_flow: got count=%0d valid=%b rd=%0d want 0 1 4", bcount, ex_valid, ex_rd_a);
        end
    endtask

    task automatic test_flush_hz();
        int c0;
        c0 = m_cnt;
        set_instr(18'h00409, 5'd2, 5'd8, 5'd0);
        tick(); model_step();
        set_instr(18'h00385, 5'd8, 5'd8, 5'd5);
        flush = 1'b1;
        #1;
        checks++;
        if (pc_wr !== 1'b0) begin
            failures++; $display("FAIL flush_hz_pc: got pc=%b want 0", pc_wr);
        end
        tick(); model_step();
        flush = 1'b0;
        checks++;
        if (ex_valid !== 1'b0 || bcount !== 16'(c0 + 1)) begin
            failures++; $display("FAIL flush_hz_bubble: got valid=%b count=%0d want 0 %0d", ex_valid, bcount, c0 + 1);
        end
    endtask

    task automatic test_halt();
        logic [17:0] c_hold;
        logic [15:0] n_hold;
        set_instr(18'h00385, 5'd6, 5'd7, 5'd11);
        tick(); model_step();
        c_hold = ex_ctrl; n_hold = bcount;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            halt = 1'b1; flush = 1'($urandom);
            #1;
            checks++;
            if (pc_wr !== 1'b0 || ifid_wr !== 1'b0) begin
                failures++; $display("FAIL halt_enables: got pc=%b ifid=%b want 0 0", pc_wr, ifid_wr);
            end
            tick(); model_step();
            checks++;
            if (ex_ctrl !== 18'h00385 || ex_rd_a !== 5'd11 || bcount !== n_hold || ex_ctrl !== c_hold) begin
                failures++; $display("FAIL halt_freeze: got ctrl=%h rd=%0d count=%0d want 00385 11 %0d", ex_ctrl, ex_rd_a, bcount, n_hold);
            end
        end
        halt = 1'b0; flush = 1'b0;
        set_instr(18'h00001, 5'd12, 5'd13, 5'd14);
        tick(); model_step();
        checks++;
        if (ex_rd_a !== 5'd14 || ex_valid !== 1'b1) begin
            failures++; $display("FAIL halt_release: got rd=%0d valid=%b want 14 1", ex_rd_a, ex_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            halt = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            #1;
            checks++;
            if ({pc_wr, ifid_wr, ctrl_en} !== {~halt & ~model_hz(), ~halt & ~model_hz(), ~model_hz()}) begin
                failures++; $display("FAIL rand_enables[%0d]: got pc/ifid/en=%b%b%b want hz=%b halt=%b", i, pc_wr, ifid_wr, ctrl_en, model_hz(), halt);
            end
            tick(); model_step();
            checks++;
            if ({ex_ctrl, ex_valid, ex_rs_a, ex_rt_a, ex_rd_a, ex_shamt, ex_rs_d, ex_rt_d, ex_imm, ex_pc4, bcount} !==
                {m_ctrl, m_valid, m_rs_a, m_rt_a, m_rd_a, m_shamt, m_rs_d, m_rt_d, m_imm, m_pc4, 16'(m_cnt)}) begin
                failures++; $display("FAIL rand_ex[%0d]: got ctrl=%h v=%b rt=%0d count=%0d want ctrl=%h v=%b rt=%0d count=%0d",
                                     i, ex_ctrl, ex_valid, ex_rt_a, bcount, m_ctrl, m_valid, m_rt_a, m_cnt);
            end
        end
        halt = 1'b0; flush = 1'b0;
    endtask

    task automatic test_saturate();
        @(negedge clk);
        force dut.bubble_count_q = 16'hFFFE;
        #1;
        release dut.bubble_count_q;
        m_cnt = 32'hFFFE;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            flush = 1'b1;
            tick(); model_step();
            checks++;
            if (bcount !== 16'hFFFF) begin
                failures++; $display("FAIL saturate[%0d]: got count=%h want ffff", i, bcount);
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_load_use();
        test_lw_zero();
        test_flush_hz();
        test_halt();
        test_random();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
